uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of the serial transmitter in the top level. Recovers 8N1 frames (1 start, 8 data LSB first, 1 stop, no parity) from the board's USB-UART line and presents each byte through a single-entry valid/ready output register. Reports framing errors and overruns as one-cycle pulses.

---
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchronizer and a single-entry
// valid/ready output register; framing errors and overruns pulse for one cycle.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_txd_in,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t        r_state;
   logic          r_meta;
   logic          r_rx_s;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_ferr;
   logic          r_ovr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_meta  <= 1'b1;
         r_rx_s  <= 1'b1;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_meta <= uart_txd_in;
         r_rx_s <= r_meta;
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
         if (r_valid && ready)
            r_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (!r_rx_s)
                  r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= r_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == BIT_M1) begin
                  r_cnt   <= '0;
                  // LSB arrives first, so shifting right lands bit i at i
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7)
                     r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == BIT_M1) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     r_state <= S_IDLE;
                     if (!r_valid || ready) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                  end else begin
                     r_ferr  <= 1'b1;
                     r_state <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BREAK: begin
               r_cnt <= '0;
               if (r_rx_s)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign data_out  = r_data;
   assign valid     = r_valid;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: bit-timed line driver pushes expected bytes,
// a negedge monitor pops and compares them as the receiver delivers.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst;
   logic       txd;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;
   logic       frame_err;
   logic       overrun;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .uart_txd_in (txd),
      .data_out    (data_out),
      .valid       (valid),
      .ready       (ready),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_vec = 0;
   int         n_mis = 0;
   int         n_arr = 0;
   int         n_ferr = 0;
   int         n_ovr = 0;
   int         last_rise = 0;
   int         t0 = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_mis++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, want, cyc);
      end
   endtask

   task automatic monitor();
      logic prev_v;
      logic prev_acc;
      prev_v   = 1'b0;
      prev_acc = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v   = 1'b0;
            prev_acc = 1'b0;
         end else begin
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (frame_err || overrun)
               chk("ferr_ovr_excl", 32'(frame_err & overrun), 32'd0);
            if (valid && (!prev_v || prev_acc)) begin
               n_arr++;
               last_rise = cyc;
               if (exp_q.size() == 0)
                  chk("unexpected_byte", 32'(data_out), 32'hFFFF);
               else
                  chk("rx_byte", 32'(data_out), 32'(exp_q.pop_front()));
            end
            prev_v   = valid;
            prev_acc = valid && ready;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      txd = b;
      idle(CPB);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input logic expect_it);
      if (expect_it && stop) exp_q.push_back(b);
      t0 = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   int a0, f0, o0;

   initial begin
      fork
         monitor();
      join_none
      rst   = 1'b1;
      txd   = 1'b1;
      ready = 1'b0;
      idle(3);
      @(negedge clk);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      idle(1);
      rst = 1'b0;
      idle(10);

      // single frame, consumer stalled
      send_frame(8'h53, 1'b1, 1'b1);
      idle(20);
      chk("s1_rise_time", 32'(last_rise - t0), 32'(CPB/2 + 3 + 9*CPB));
      chk("s1_valid", 32'(valid), 32'd1);
      chk("s1_hold", 32'(data_out), 32'h53);
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      @(negedge clk);
      chk("s1_clear", 32'(valid), 32'd0);
      idle(5);

      // back-to-back frames, ready tied high
      ready = 1'b1;
      a0 = n_arr; f0 = n_ferr; o0 = n_ovr;
      send_frame(8'hA5, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      idle(20);
      chk("s2_count", 32'(n_arr - a0), 32'd2);
      chk("s2_ferr", 32'(n_ferr - f0), 32'd0);
      chk("s2_ovr", 32'(n_ovr - o0), 32'd0);

      // short glitch on idle line
      a0 = n_arr; f0 = n_ferr;
      txd = 1'b0;
      idle(5);
      txd = 1'b1;
      idle(40);
      chk("s3_no_byte", 32'(n_arr - a0), 32'd0);
      chk("s3_no_ferr", 32'(n_ferr - f0), 32'd0);
      send_frame(8'h00, 1'b1, 1'b1);
      idle(20);
      chk("s3_count", 32'(n_arr - a0), 32'd1);

      // framing error followed by a held-low line
      a0 = n_arr; f0 = n_ferr;
      send_frame(8'hFF, 1'b0, 1'b0);
      txd = 1'b0;
      idle(40);
      txd = 1'b1;
      idle(30);
      chk("s4_ferr", 32'(n_ferr - f0), 32'd1);
      chk("s4_no_byte", 32'(n_arr - a0), 32'd0);
      chk("s4_valid", 32'(valid), 32'd0);
      send_frame(8'h81, 1'b1, 1'b1);
      idle(20);
      chk("s4_count", 32'(n_arr - a0), 32'd1);

      // overrun, then accept exactly on a delivery cycle
      ready = 1'b0;
      o0 = n_ovr;
      send_frame(8'h11, 1'b1, 1'b1);
      idle(10);
      send_frame(8'h22, 1'b1, 1'b0);
      idle(10);
      chk("s5_keep", 32'(data_out), 32'h11);
      chk("s5_ovr", 32'(n_ovr - o0), 32'd1);
      o0 = n_ovr;
      fork
         send_frame(8'h33, 1'b1, 1'b1);
         begin
            idle(CPB/2 + 2 + 9*CPB);
            ready = 1'b1;
            idle(1);
            ready = 1'b0;
         end
      join
      idle(10);
      chk("s5_new", 32'(data_out), 32'h33);
      chk("s5_valid", 32'(valid), 32'd1);
      chk("s5_no_ovr", 32'(n_ovr - o0), 32'd0);

      // reset in the middle of a frame
      f0 = n_ferr; o0 = n_ovr;
      fork
         send_frame(8'hC3, 1'b1, 1'b0);
         begin
            idle(5*CPB + 4);
            rst = 1'b1;
            idle(2);
            @(negedge clk);
            chk("s6_valid", 32'(valid), 32'd0);
            chk("s6_data", 32'(data_out), 32'd0);
            chk("s6_ferr", 32'(frame_err), 32'd0);
            chk("s6_ovr", 32'(overrun), 32'd0);
         end
      join
      idle(5);
      rst = 1'b0;
      idle(20);
      ready = 1'b1;
      a0 = n_arr;
      send_frame(8'h5A, 1'b1, 1'b1);
      idle(20);
      chk("s6_count", 32'(n_arr - a0), 32'd1);
      chk("s6_no_pulse", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
